// File: rtl/fpro_bus_arbiter_pkg.sv
// Shared types and constants for the two-master FPro MMIO bus arbiter.
package fpro_arb_pkg;

    localparam int FPRO_ADDR_W = 21;
    localparam int FPRO_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    typedef logic mid_t;

    localparam mid_t MID_M0 = 1'b0;
    localparam mid_t MID_M1 = 1'b1;

endpackage

// File: rtl/fpro_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; with FPRO_ARB_LOCK_EN a locked
// master is the only eligible requester.
module rr_arb2
    import fpro_arb_pkg::*;
(
    input  logic [1:0] req,
    input  mid_t       last_grant,
`ifdef FPRO_ARB_LOCK_EN
    input  logic       locked,
    input  mid_t       locked_id,
`endif
    output logic       gnt_valid,
    output mid_t       gnt_id
);

    logic [1:0] eligible;

    always_comb begin
        eligible = req;
`ifdef FPRO_ARB_LOCK_EN
        if (locked) begin
            eligible = req & ((locked_id == MID_M1) ? 2'b10 : 2'b01);
        end
`endif
        gnt_valid = |eligible;
        // On a tie the master that was not served last goes first.
        case (eligible)
            2'b11:   gnt_id = ~last_grant;
            2'b10:   gnt_id = MID_M1;
            default: gnt_id = MID_M0;
        endcase
    end

endmodule

// File: rtl/fpro_bus_arbiter.sv
// Shares the FPro MMIO bus between two masters, one sequenced access at a time
// (IDLE -> ACCESS -> ACK). Optional lock ports under FPRO_ARB_LOCK_EN.
module fpro_bus_arbiter
    import fpro_arb_pkg::*;
#(
    parameter int ADDR_W = FPRO_ADDR_W,
    parameter int DATA_W = FPRO_DATA_W
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              fp_mmio_cs,
    output logic              fp_wr,
    output logic              fp_rd,
    output logic [ADDR_W-1:0] fp_addr,
    output logic [DATA_W-1:0] fp_wr_data,
    input  logic [DATA_W-1:0] fp_rd_data
`ifdef FPRO_ARB_LOCK_EN
    ,
    input  logic              m0_lock,
    input  logic              m1_lock
`endif
);

    state_t            state_q, state_d;
    mid_t              winner_q, winner_d;
    mid_t              last_grant_q, last_grant_d;
    logic              fp_cs_q, fp_cs_d;
    logic              fp_wr_q, fp_wr_d;
    logic              fp_rd_q, fp_rd_d;
    logic [ADDR_W-1:0] fp_addr_q, fp_addr_d;
    logic [DATA_W-1:0] fp_wr_data_q, fp_wr_data_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_rd_data_q, m0_rd_data_d;
    logic [DATA_W-1:0] m1_rd_data_q, m1_rd_data_d;

`ifdef FPRO_ARB_LOCK_EN
    logic              locked_q, locked_d;
    mid_t              locked_id_q, locked_id_d;
    logic              cur_lock_q, cur_lock_d;
`endif

    logic              gnt_valid;
    mid_t              gnt_id;

    rr_arb2 u_rr_arb2 (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
`ifdef FPRO_ARB_LOCK_EN
        .locked     (locked_q),
        .locked_id  (locked_id_q),
`endif
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        fp_cs_d      = 1'b0;
        fp_wr_d      = 1'b0;
        fp_rd_d      = 1'b0;
        fp_addr_d    = fp_addr_q;
        fp_wr_data_d = fp_wr_data_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rd_data_d = m0_rd_data_q;
        m1_rd_data_d = m1_rd_data_q;
`ifdef FPRO_ARB_LOCK_EN
        locked_d     = locked_q;
        locked_id_d  = locked_id_q;
        cur_lock_d   = cur_lock_q;
`endif

        case (state_q)
            IDLE: begin
                // The strobes are set up here so they are registered in ACCESS.
                if (gnt_valid) begin
                    winner_d = gnt_id;
                    fp_cs_d  = 1'b1;
                    if (gnt_id == MID_M1) begin
                        fp_wr_d      = m1_wr;
                        fp_rd_d      = ~m1_wr;
                        fp_addr_d    = m1_addr;
                        fp_wr_data_d = m1_wr_data;
                    end else begin
                        fp_wr_d      = m0_wr;
                        fp_rd_d      = ~m0_wr;
                        fp_addr_d    = m0_addr;
                        fp_wr_data_d = m0_wr_data;
                    end
`ifdef FPRO_ARB_LOCK_EN
                    cur_lock_d = (gnt_id == MID_M1) ? m1_lock : m0_lock;
`endif
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                if (fp_rd_q) begin
                    if (winner_q == MID_M1) begin
                        m1_rd_data_d = fp_rd_data;
                    end else begin
                        m0_rd_data_d = fp_rd_data;
                    end
                end
                if (winner_q == MID_M1) begin
                    m1_ack_d = 1'b1;
                end else begin
                    m0_ack_d = 1'b1;
                end
                state_d = ACK;
            end

            ACK: begin
                last_grant_d = winner_q;
`ifdef FPRO_ARB_LOCK_EN
                // A completed unlocked access from the owner releases the lock.
                locked_d    = cur_lock_q;
                locked_id_d = winner_q;
`endif
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            winner_q     <= MID_M0;
            last_grant_q <= MID_M1;
            fp_cs_q      <= 1'b0;
            fp_wr_q      <= 1'b0;
            fp_rd_q      <= 1'b0;
            fp_addr_q    <= '0;
            fp_wr_data_q <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rd_data_q <= '0;
            m1_rd_data_q <= '0;
`ifdef FPRO_ARB_LOCK_EN
            locked_q     <= 1'b0;
            locked_id_q  <= MID_M0;
            cur_lock_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            fp_cs_q      <= fp_cs_d;
            fp_wr_q      <= fp_wr_d;
            fp_rd_q      <= fp_rd_d;
            fp_addr_q    <= fp_addr_d;
            fp_wr_data_q <= fp_wr_data_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rd_data_q <= m0_rd_data_d;
            m1_rd_data_q <= m1_rd_data_d;
`ifdef FPRO_ARB_LOCK_EN
            locked_q     <= locked_d;
            locked_id_q  <= locked_id_d;
            cur_lock_q   <= cur_lock_d;
`endif
        end
    end

    assign fp_mmio_cs = fp_cs_q;
    assign fp_wr      = fp_wr_q;
    assign fp_rd      = fp_rd_q;
    assign fp_addr    = fp_addr_q;
    assign fp_wr_data = fp_wr_data_q;
    assign m0_ack     = m0_ack_q;
    assign m1_ack     = m1_ack_q;
    assign m0_rd_data = m0_rd_data_q;
    assign m1_rd_data = m1_rd_data_q;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Self-checking bench for fpro_bus_arbiter: vector table plus scoreboard of
// expected bus accesses; lock sequence runs when FPRO_ARB_LOCK_EN is defined.
module tb_fpro_bus_arbiter;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset_n;
    logic              m0_req, m0_wr, m1_req, m1_wr;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wr_data, m1_wr_data;
    logic              m0_ack, m1_ack;
    logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
    logic              fp_mmio_cs, fp_wr, fp_rd;
    logic [ADDR_W-1:0] fp_addr;
    logic [DATA_W-1:0] fp_wr_data;
    logic [DATA_W-1:0] fp_rd_data;
    logic [DATA_W-1:0] slot;
`ifdef FPRO_ARB_LOCK_EN
    logic              m0_lock, m1_lock;
`endif

    typedef struct {
        logic              m0_req;
        logic              m0_wr;
        logic [ADDR_W-1:0] m0_addr;
        logic [DATA_W-1:0] m0_wdata;
        logic              m1_req;
        logic              m1_wr;
        logic [ADDR_W-1:0] m1_addr;
        logic [DATA_W-1:0] m1_wdata;
        logic [DATA_W-1:0] slot;
        logic              exp_first;
    } vec_t;

    typedef struct {
        logic              id;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] exp_rd[2];
    vec_t              vecs[8];
    int                checks = 0;
    int                errors = 0;

    fpro_bus_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_addr    (m0_addr),
        .m0_wr_data (m0_wr_data),
        .m0_ack     (m0_ack),
        .m0_rd_data (m0_rd_data),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_addr    (m1_addr),
        .m1_wr_data (m1_wr_data),
        .m1_ack     (m1_ack),
        .m1_rd_data (m1_rd_data),
        .fp_mmio_cs (fp_mmio_cs),
        .fp_wr      (fp_wr),
        .fp_rd      (fp_rd),
        .fp_addr    (fp_addr),
        .fp_wr_data (fp_wr_data),
        .fp_rd_data (fp_rd_data)
`ifdef FPRO_ARB_LOCK_EN
        ,
        .m0_lock    (m0_lock),
        .m1_lock    (m1_lock)
`endif
    );

    assign fp_rd_data = slot;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic pushExp(input logic id, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata);
        exp_t e;
        e.id = id; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_m0_ack"}, 64'(m0_ack), 64'd0);
        check({tag, "_m1_ack"}, 64'(m1_ack), 64'd0);
        check({tag, "_m0_rd_data"}, 64'(m0_rd_data), 64'd0);
        check({tag, "_m1_rd_data"}, 64'(m1_rd_data), 64'd0);
        check({tag, "_cs"}, 64'(fp_mmio_cs), 64'd0);
        check({tag, "_wr"}, 64'(fp_wr), 64'd0);
        check({tag, "_rd"}, 64'(fp_rd), 64'd0);
        check({tag, "_addr"}, 64'(fp_addr), 64'd0);
        check({tag, "_wdata"}, 64'(fp_wr_data), 64'd0);
    endtask

    // Per-cycle monitor: bus strobes match the head of the scoreboard and
    // each ack retires it with the right master and read data.
    task automatic checkOutput();
        exp_t e;
        check("ack_onehot", 64'(m0_ack & m1_ack), 64'd0);
        check("wr_rd_excl", 64'(fp_wr & fp_rd), 64'd0);
        if (fp_mmio_cs) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                e = sb[0];
                check("strobe_wr", 64'(fp_wr), 64'(e.wr));
                check("strobe_rd", 64'(fp_rd), 64'(!e.wr));
                check("strobe_addr", 64'(fp_addr), 64'(e.addr));
                if (e.wr) check("strobe_wdata", 64'(fp_wr_data), 64'(e.wdata));
            end
        end else begin
            check("idle_strobes", 64'(fp_wr | fp_rd), 64'd0);
        end
        if (m0_ack || m1_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("ack_id", 64'(m1_ack), 64'(e.id));
                if (!e.wr) exp_rd[e.id] = e.rdata;
                if (e.id) check("m1_rd_data", 64'(m1_rd_data), 64'(exp_rd[1]));
                else      check("m0_rd_data", 64'(m0_rd_data), 64'(exp_rd[0]));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input vec_t v);
        logic second;
        m0_req = v.m0_req; m0_wr = v.m0_wr; m0_addr = v.m0_addr; m0_wr_data = v.m0_wdata;
        m1_req = v.m1_req; m1_wr = v.m1_wr; m1_addr = v.m1_addr; m1_wr_data = v.m1_wdata;
        slot = v.slot;
        second = ~v.exp_first;
        if (v.exp_first) pushExp(1'b1, v.m1_wr, v.m1_addr, v.m1_wdata, v.slot);
        else             pushExp(1'b0, v.m0_wr, v.m0_addr, v.m0_wdata, v.slot);
        if (v.m0_req && v.m1_req) begin
            if (second) pushExp(1'b1, v.m1_wr, v.m1_addr, v.m1_wdata, v.slot);
            else        pushExp(1'b0, v.m0_wr, v.m0_addr, v.m0_wdata, v.slot);
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int n_exp, first_strobe, n_ack;
        int ack_t[2];
        applyStimulus(v);
        n_exp = sb.size();
        first_strobe = -1;
        n_ack = 0;
        ack_t[0] = -1; ack_t[1] = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (fp_mmio_cs && first_strobe < 0) first_strobe = t;
            if (m0_ack || m1_ack) begin
                if (n_ack < 2) ack_t[n_ack] = t;
                n_ack++;
            end
            if (m0_ack) m0_req = 1'b0;
            if (m1_ack) m1_req = 1'b0;
            if (sb.size() == 0 && !m0_req && !m1_req) break;
        end
        check({tag, "_all_served"}, 64'(sb.size()), 64'd0);
        check({tag, "_strobe_latency"}, 64'(first_strobe), 64'd1);
        check({tag, "_ack_latency"}, 64'(ack_t[0]), 64'd2);
        if (n_exp == 2) check({tag, "_second_ack"}, 64'(ack_t[1]), 64'd5);
        sb.delete();
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt[2];
        int ack_ticks[$];
        int total;

        vecs[0] = '{1'b1, 1'b1, 21'h00100, 32'h0000_00AB, 1'b0, 1'b0, 21'h0, 32'h0, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 21'h0, 32'h0, 1'b1, 1'b0, 21'h00204, 32'h0, 32'hDEAD_BEEF, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 21'h00300, 32'h0, 1'b1, 1'b1, 21'h00304, 32'h55, 32'h1357_2468, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 21'h00040, 32'h0, 1'b0, 1'b0, 21'h0, 32'h0, 32'h1234_5678, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 21'h00044, 32'h2222, 1'b1, 1'b0, 21'h00048, 32'h0, 32'h0BAD_F00D, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 21'h0, 32'h0, 1'b1, 1'b1, 21'h1FFFFF, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 21'h00000, 32'h0, 1'b0, 1'b0, 21'h0, 32'h0, 32'h0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 21'h00700, 32'h77, 1'b1, 1'b1, 21'h00704, 32'h88, 32'h0, 1'b0};

        reset_n = 1'b0;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wr_data = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wr_data = '0;
        slot = '0;
`ifdef FPRO_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
        exp_rd[0] = '0; exp_rd[1] = '0;
        tick();
        tick();
        checkReset("reset");
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset lands while an m0 write is on the bus.
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h00600; m0_wr_data = 32'h66;
        pushExp(1'b0, 1'b1, 21'h00600, 32'h66, 32'h0);
        tick();
        check("pre_reset_cs", 64'(fp_mmio_cs), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkReset("async_reset");
        sb.delete();
        exp_rd[0] = '0; exp_rd[1] = '0;
        m0_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        runVector(vecs[7], "post_reset");

        // Both masters request back to back; grants must alternate.
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h00500; m0_wr_data = 32'hA0;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 21'h00504; m1_wr_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            pushExp(1'b0, 1'b1, 21'h00500, 32'hA0, 32'h0);
            pushExp(1'b1, 1'b1, 21'h00504, 32'hB0, 32'h0);
        end
        cnt[0] = 0; cnt[1] = 0; total = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (m0_ack || m1_ack) begin
                total++;
                ack_ticks.push_back(t);
                if (t <= 24) begin
                    if (m1_ack) cnt[1]++;
                    else        cnt[0]++;
                end
            end
            if (total == 8) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
            if (sb.size() == 0 && !m0_req && !m1_req) break;
        end
        check("rr_all_served", 64'(sb.size()), 64'd0);
        check("rr_m0_acks", 64'(cnt[0]), 64'd4);
        check("rr_m1_acks", 64'(cnt[1]), 64'd4);
        check("rr_first_ack", 64'(ack_ticks.size() > 0 ? ack_ticks[0] : -1), 64'd2);
        for (int i = 1; i < ack_ticks.size(); i++) begin
            check($sformatf("rr_spacing%0d", i), 64'(ack_ticks[i] - ack_ticks[i-1]), 64'd3);
        end
        sb.delete();
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

`ifdef FPRO_ARB_LOCK_EN
        // Locked read then unlocked write from m0 must both beat m1.
        begin
            int m0_done;
            int m1_ack_tick;
            m0_done = 0;
            m1_ack_tick = -1;
            slot = 32'h5A5A_5A5A;
            m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00010; m0_lock = 1'b1;
            m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00020; m1_lock = 1'b0;
            pushExp(1'b0, 1'b0, 21'h00010, 32'h0, 32'h5A5A_5A5A);
            pushExp(1'b0, 1'b1, 21'h00010, 32'h5A5A_5A5B, 32'h0);
            pushExp(1'b1, 1'b0, 21'h00020, 32'h0, 32'h5A5A_5A5A);
            for (int t = 1; t <= 30; t++) begin
                tick();
                if (m0_ack) begin
                    m0_done++;
                    if (m0_done == 1) begin
                        m0_wr = 1'b1; m0_lock = 1'b0; m0_wr_data = 32'h5A5A_5A5B;
                    end else begin
                        m0_req = 1'b0;
                    end
                end
                if (m1_ack) begin
                    m1_req = 1'b0;
                    m1_ack_tick = t;
                end
                if (sb.size() == 0 && !m0_req && !m1_req) break;
            end
            check("lock_all_served", 64'(sb.size()), 64'd0);
            check("lock_m1_ack_tick", 64'(m1_ack_tick), 64'd8);
            sb.delete();
            m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0;
            tick();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
